wim_toggle_monitor: RTL

WIM_TOGGLE_MONITOR -- requirements
Module: wim_toggle_monitor

---
 rtl/wim_toggle_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wim_toggle_monitor.sv
// ============================================================================
//  Module      : wim_toggle_monitor
//  Description : Windowed bit-toggle monitor for the 7-bit WIM decoder output;
//                accumulates per-sample Hamming distance and tracks its maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wim_toggle_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_word,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [2:0]       max_hd
);

  localparam logic [1:0]       c_ST_IDLE  = 2'd0;
  localparam logic [1:0]       c_ST_FIRST = 2'd1;
  localparam logic [1:0]       c_ST_ACC   = 2'd2;
  localparam logic [1:0]       c_ST_DONE  = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [6:0]       r_prev;
  logic [8:0]       r_remaining;
  logic [CNT_W-1:0] r_toggle_cnt;
  logic [2:0]       r_max_hd;
  logic             r_done;

  logic             w_accept;
  logic             w_start_ok;
  logic             w_last;
  logic [6:0]       w_xor;
  logic [2:0]       w_hd;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_sat;

  assign w_accept   = in_valid & in_ready;
  assign w_start_ok = start & ~abort & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));
  assign w_last     = (r_remaining == 9'd1);

  // Per-bit toggle detect against the previously accepted word
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_toggle_bit
      assign w_xor[gi] = in_word[gi] ^ r_prev[gi];
    end
  endgenerate

  always_comb begin
    w_hd = 3'd0;
    for (int i = 0; i < 7; i++) begin
      w_hd = w_hd + {2'b00, w_xor[i]};
    end
  end

  assign w_sum = {1'b0, r_toggle_cnt} + {{(CNT_W-2){1'b0}}, w_hd};
  assign w_sat = w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort overrides every other request
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) w_next_state = c_ST_FIRST;
        end
        c_ST_FIRST: begin
          if (w_accept) w_next_state = w_last ? c_ST_DONE : c_ST_ACC;
        end
        c_ST_ACC: begin
          if (w_accept && w_last) w_next_state = c_ST_DONE;
        end
        c_ST_DONE: begin
          if (start) w_next_state = c_ST_FIRST;
        end
        default: w_next_state = c_ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready = (r_state == c_ST_FIRST) | (r_state == c_ST_ACC);
    busy     = (r_state == c_ST_FIRST) | (r_state == c_ST_ACC);
    done     = r_done;
  end

  // Window datapath; results stay frozen after abort until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= 7'd0;
      r_remaining  <= 9'd0;
      r_toggle_cnt <= '0;
      r_max_hd     <= 3'd0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (w_next_state == c_ST_DONE) && (r_state != c_ST_DONE);
      if (!abort) begin
        if (w_start_ok) begin
          r_remaining  <= (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
          r_toggle_cnt <= '0;
          r_max_hd     <= 3'd0;
        end else if (w_accept) begin
          r_prev      <= in_word;
          r_remaining <= r_remaining - 9'd1;
          if (r_state == c_ST_ACC) begin
            r_toggle_cnt <= w_sat;
            if (w_hd > r_max_hd) r_max_hd <= w_hd;
          end
        end
      end
    end
  end

  assign toggle_cnt = r_toggle_cnt;
  assign max_hd     = r_max_hd;

endmodule

`default_nettype wire
